tail_pwm_dimmer: RTL and testbench
==================================

Name: tail_pwm_dimmer

Overview:
- Parametrised successor to the 1-bit toggle dimmer. Drives N tail-light channels from a shared PWM counter. Each channel has its own brightness level.
- Per channel: pattern bit set -> full on; pattern bit clear with running lights enabled -> programmable dim level; otherwise off.
- Sits between the tail-light sequencer pattern outputs and the LED pins. Clocked by the dimming clock.

Parameters:
- N_LIGHTS, 6, number of light channels.
- PWM_BITS, 4, PWM counter width; period = 2**PWM_BITS cycles.
- DIM_LEVEL, 8, running-light brightness in counts, range 0..2**PWM_BITS (8 of 16 = 50%).
- FADE_PERIODS, 2, PWM periods between fade steps; used only when fade is compiled in; must be >= 1.

Ports:
- dimclk  in  1  dimming clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- runlight  in  1  running-light enable; 0 = legacy direct mode (lights track patterns).
- patterns  in  N_LIGHTS  per-channel request from sequencer; 1 = full on.
- lights  out  N_LIGHTS  registered PWM light drive.
- settled  out  1  registered; 1 when every channel level equals its target.

Behaviour:
- Reset is synchronous, active-high, on dimclk. It sets: pwm_cnt = 0, all level[i] = 0, fade period counter = 0, lights = 0, settled = 1.
- Reset asserted mid-operation wins over all other updates in that cycle.

- PWM counter:
  - pwm_cnt is PWM_BITS wide and increments every cycle.
  - It wraps from MAX = 2**PWM_BITS-1 to 0.
  - A period boundary is any cycle with pwm_cnt == MAX.

- Per-channel target (combinational, PWM_BITS+1 bits wide):
  - patterns[i] = 1 -> FULL = 2**PWM_BITS.
  - patterns[i] = 0 and runlight = 1 -> DIM_LEVEL.
  - patterns[i] = 0 and runlight = 0 -> 0.

- Level register:
  - level[i] is PWM_BITS+1 bits wide.
  - It updates only on a period boundary, so no duty change happens mid-period (glitch-free).
  - Inputs are sampled every cycle. Only the value present on the boundary cycle takes effect; pulses shorter than a period that miss the boundary are ignored.

- Output:
  - lights[i] <= (pwm_cnt < level[i]), one cycle of registration.
  - level = FULL -> constant 1; level = 0 -> constant 0; level = k -> high for k cycles of each period.

- Latency: a pattern change is reflected on lights one cycle after the first boundary at which it is sampled. Worst case is 2**PWM_BITS+1 cycles (fade off).

- settled <= (level == target for all i), evaluated every cycle from the current values.

- Boundary cases:
  - DIM_LEVEL = 0: running light is dark.
  - DIM_LEVEL = FULL: running light is indistinguishable from full on.
  - Simultaneous runlight and patterns changes resolve through the target mux in the same cycle; there are no ordering effects.

Optional Feature:
- Macro: TAIL_PWM_FADE_EN.
- Defined:
  - A fade counter counts period boundaries. A fade tick occurs on every FADE_PERIODS-th boundary, after which the counter restarts.
  - On a fade tick each level[i] moves 1 count toward target[i], then holds at the target (no overshoot). No level change happens on non-tick boundaries.
  - A full 0 -> FULL ramp takes 2**PWM_BITS ticks.
  - A target reversal mid-ramp reverses direction from the current level.
- Undefined:
  - level[i] loads target[i] directly at every boundary.
  - No fade counter exists; FADE_PERIODS is ignored.

Test Plan (N_LIGHTS=6, PWM_BITS=4, DIM_LEVEL=8, FADE_PERIODS=2):
1. Reset held 3 cycles with patterns=6'b111111 -> lights=0, settled=1. After release, lights=6'b111111 from the cycle after the first boundary (cycle 17) onward, constant.
2. runlight=1, patterns=0, fade off -> after the first boundary every light is high 8 cycles, low 8 cycles per 16-cycle period.
3. runlight=0, patterns=6'b000101 -> lights settle to 6'b000101 constant. Toggling patterns[2] at pwm_cnt=5 does not change lights until one cycle after the next boundary.
4. Fade on: runlight=1, patterns=6'b000001, starting from reset -> level[0] ramps 0 -> 16 and level[1..5] ramp 0 -> 8, one step every 32 cycles. settled stays 0 until level[0]=16 (16 ticks); channel 1 duty is exactly 8/16 after 8 ticks.
5. Fade on: clear patterns[0] when level[0]=12 -> level[0] steps down 12 -> 8 over 4 ticks, then holds; settled returns to 1.
6. Assert reset mid-period at pwm_cnt=9 with mixed levels -> the next cycle shows pwm_cnt=0, lights=0, settled=1. No residual duty remains and the fade counter is cleared.

Source files
------------

// File: rtl/tail_pwm_dimmer.sv
// tail_pwm_dimmer: N-channel tail-light PWM dimmer driven from one shared counter.
// Define TAIL_PWM_FADE_EN to make levels ramp one count per fade tick instead of jumping.
module tail_pwm_dimmer #(
  parameter int N_LIGHTS     = 6,
  parameter int PWM_BITS     = 4,
  parameter int DIM_LEVEL    = 8,
  parameter int FADE_PERIODS = 2
) (
  input  logic                dimclk,
  input  logic                reset,
  input  logic                runlight,
  input  logic [N_LIGHTS-1:0] patterns,
  output logic [N_LIGHTS-1:0] lights,
  output logic                settled
);

  localparam int LW = PWM_BITS + 1;
  localparam logic [LW-1:0]       FULL = LW'(2 ** PWM_BITS);
  localparam logic [LW-1:0]       DIM  = LW'(DIM_LEVEL);
  localparam logic [PWM_BITS-1:0] MAX  = {PWM_BITS{1'b1}};

  if (FADE_PERIODS < 1 || DIM_LEVEL < 0 || DIM_LEVEL > 2 ** PWM_BITS) begin : g_param_check
    $error("tail_pwm_dimmer: invalid FADE_PERIODS or DIM_LEVEL");
  end

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [LW-1:0]       level      [N_LIGHTS];
  logic [LW-1:0]       target     [N_LIGHTS];
  logic [LW-1:0]       level_next [N_LIGHTS];
  logic                boundary;
  logic                step;
  logic                all_equal;

  assign boundary = (pwm_cnt == MAX);

  always_comb begin
    for (int i = 0; i < N_LIGHTS; i++) begin
      target[i] = '0;
      if (patterns[i]) begin
        target[i] = FULL;
      end else if (runlight) begin
        target[i] = DIM;
      end
    end
  end

  always_comb begin
    all_equal = 1'b1;
    for (int i = 0; i < N_LIGHTS; i++) begin
      if (level[i] != target[i]) begin
        all_equal = 1'b0;
      end
    end
  end

`ifdef TAIL_PWM_FADE_EN
  localparam int FW = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
  localparam logic [FW-1:0] FADE_LAST = FW'(FADE_PERIODS - 1);

  logic [FW-1:0] fade_cnt;

  // Counts period boundaries; the last one of each group is the fade tick.
  always_ff @(posedge dimclk) begin
    if (reset) begin
      fade_cnt <= '0;
    end else if (boundary) begin
      fade_cnt <= (fade_cnt == FADE_LAST) ? '0 : fade_cnt + FW'(1);
    end
  end

  assign step = boundary && (fade_cnt == FADE_LAST);

  always_comb begin
    for (int i = 0; i < N_LIGHTS; i++) begin
      level_next[i] = level[i];
      if (level[i] < target[i]) begin
        level_next[i] = level[i] + LW'(1);
      end else if (level[i] > target[i]) begin
        level_next[i] = level[i] - LW'(1);
      end
    end
  end
`else
  assign step = boundary;

  always_comb begin
    for (int i = 0; i < N_LIGHTS; i++) begin
      level_next[i] = target[i];
    end
  end
`endif

  // Levels only move on a period boundary so a duty cycle never changes mid-period.
  always_ff @(posedge dimclk) begin
    if (reset) begin
      pwm_cnt <= '0;
      lights  <= '0;
      settled <= 1'b1;
      for (int i = 0; i < N_LIGHTS; i++) begin
        level[i] <= '0;
      end
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      settled <= all_equal;
      for (int i = 0; i < N_LIGHTS; i++) begin
        lights[i] <= ({1'b0, pwm_cnt} < level[i]);
        if (step) begin
          level[i] <= level_next[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_tail_pwm_dimmer.sv
// tb_tail_pwm_dimmer: directed bench with a cycle-level behavioural model of the dimmer.
// Fade scenarios run when TAIL_PWM_FADE_EN is defined, direct-mode scenarios otherwise.
module tb_tail_pwm_dimmer;

  localparam int N_LIGHTS     = 6;
  localparam int PWM_BITS     = 4;
  localparam int DIM_LEVEL    = 8;
  localparam int FADE_PERIODS = 2;
  localparam int PERIOD       = 1 << PWM_BITS;

  logic                dimclk;
  logic                reset;
  logic                runlight;
  logic [N_LIGHTS-1:0] patterns;
  logic [N_LIGHTS-1:0] lights;
  logic                settled;
  logic [1:0]          darkLights;
  logic                darkSettled;
  logic [1:0]          brightLights;
  logic                brightSettled;

  int checks = 0;
  int passes = 0;
  bit checkEn = 0;

  tail_pwm_dimmer #(
    .N_LIGHTS(N_LIGHTS), .PWM_BITS(PWM_BITS), .DIM_LEVEL(DIM_LEVEL), .FADE_PERIODS(FADE_PERIODS)
  ) dut (
    .dimclk(dimclk), .reset(reset), .runlight(runlight),
    .patterns(patterns), .lights(lights), .settled(settled)
  );

  tail_pwm_dimmer #(
    .N_LIGHTS(2), .PWM_BITS(PWM_BITS), .DIM_LEVEL(0), .FADE_PERIODS(FADE_PERIODS)
  ) uDark (
    .dimclk(dimclk), .reset(reset), .runlight(runlight),
    .patterns(patterns[1:0]), .lights(darkLights), .settled(darkSettled)
  );

  tail_pwm_dimmer #(
    .N_LIGHTS(2), .PWM_BITS(PWM_BITS), .DIM_LEVEL(PERIOD), .FADE_PERIODS(FADE_PERIODS)
  ) uBright (
    .dimclk(dimclk), .reset(reset), .runlight(runlight),
    .patterns(patterns[1:0]), .lights(brightLights), .settled(brightSettled)
  );

  initial begin
    dimclk = 1'b0;
    forever #5 dimclk = ~dimclk;
  end

  // Behavioural model: phase within the period, integer brightness per channel.
  int                  mPhase;
  int                  mFadeCnt;
  int                  mLevel [N_LIGHTS];
  logic [N_LIGHTS-1:0] mLights;
  logic                mSettled;

  function automatic int targetOf(int i, logic rl, logic [N_LIGHTS-1:0] p);
    if (p[i]) return PERIOD;
    if (rl) return DIM_LEVEL;
    return 0;
  endfunction

  initial begin
    logic [N_LIGHTS-1:0] nl;
    bit allEq;
    bit tick;
    int t;
    mPhase = 0;
    mFadeCnt = 0;
    mLights = '0;
    mSettled = 1'b1;
    foreach (mLevel[i]) mLevel[i] = 0;
    forever begin
      @(posedge dimclk);
      if (reset) begin
        mPhase = 0;
        mFadeCnt = 0;
        mLights = '0;
        mSettled = 1'b1;
        foreach (mLevel[i]) mLevel[i] = 0;
      end else begin
        allEq = 1;
        for (int i = 0; i < N_LIGHTS; i++) begin
          nl[i] = (mPhase < mLevel[i]);
          if (mLevel[i] != targetOf(i, runlight, patterns)) allEq = 0;
        end
        mLights = nl;
        mSettled = allEq;
        if (mPhase == PERIOD - 1) begin
          tick = 1;
`ifdef TAIL_PWM_FADE_EN
          mFadeCnt++;
          tick = (mFadeCnt == FADE_PERIODS);
          if (tick) mFadeCnt = 0;
`endif
          if (tick) begin
            for (int i = 0; i < N_LIGHTS; i++) begin
              t = targetOf(i, runlight, patterns);
`ifdef TAIL_PWM_FADE_EN
              if (mLevel[i] < t) mLevel[i]++;
              else if (mLevel[i] > t) mLevel[i]--;
`else
              mLevel[i] = t;
`endif
            end
          end
        end
        mPhase = (mPhase + 1) % PERIOD;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model, away from the clock edge.
  initial begin
    forever begin
      @(negedge dimclk);
      if (checkEn) begin
        checkOutput("model_lights", 32'(lights), 32'(mLights));
        checkOutput("model_settled", 32'(settled), 32'(mSettled));
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic rl, input logic [N_LIGHTS-1:0] pat);
    @(negedge dimclk);
    reset = rst;
    runlight = rl;
    patterns = pat;
  endtask

  task automatic waitPhase(input int ph);
    int n = 0;
    while (mPhase != ph && n < 2 * PERIOD) begin
      @(negedge dimclk);
      n++;
    end
    if (mPhase != ph) checkOutput("phase_wait_timeout", 32'(mPhase), 32'(ph));
  endtask

  task automatic dutyOfChannel(input int ch, output int highs);
    highs = 0;
    for (int k = 0; k < PERIOD; k++) begin
      @(negedge dimclk);
      if (lights[ch]) highs++;
    end
  endtask

  initial begin
    int highs;
    int n;
    reset = 1'b1;
    runlight = 1'b0;
    patterns = 6'b111111;
`ifdef TAIL_PWM_FADE_EN
    runlight = 1'b1;
    patterns = 6'b000001;
    @(posedge dimclk);
    @(negedge dimclk);
    checkEn = 1;
    checkOutput("reset_lights", 32'(lights), 32'h0);
    checkOutput("reset_settled", 32'(settled), 32'h1);
    repeat (2) @(negedge dimclk);
    reset = 1'b0;
    for (int k = 1; k <= 256; k++) @(negedge dimclk);
    checkOutput("model_pin_level1", 32'(mLevel[1]), 32'd8);
    dutyOfChannel(1, highs);
    checkOutput("fade_ch1_duty", 32'(highs), 32'd8);
    for (int k = 273; k <= 512; k++) @(negedge dimclk);
    checkOutput("fade_settled_before_full", 32'(settled), 32'h0);
    @(negedge dimclk);
    checkOutput("fade_settled_at_full", 32'(settled), 32'h1);
    checkOutput("fade_lights_full", 32'(lights[0]), 32'h1);

    applyStimulus(1'b1, 1'b1, 6'b000001);
    applyStimulus(1'b0, 1'b1, 6'b000001);
    n = 0;
    while (mLevel[0] != 12 && n < 600) begin
      @(negedge dimclk);
      n++;
    end
    checkOutput("fade_reach12", 32'(mLevel[0]), 32'd12);
    patterns = 6'b000000;
    repeat (200) @(negedge dimclk);
    checkOutput("model_pin_level0", 32'(mLevel[0]), 32'd8);
    checkOutput("fade_down_settled", 32'(settled), 32'h1);
    dutyOfChannel(0, highs);
    checkOutput("fade_down_duty", 32'(highs), 32'd8);
`else
    @(posedge dimclk);
    @(negedge dimclk);
    checkEn = 1;
    checkOutput("reset_lights", 32'(lights), 32'h0);
    checkOutput("reset_settled", 32'(settled), 32'h1);
    repeat (2) @(negedge dimclk);
    reset = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge dimclk);
      if (k == 16) begin
        checkOutput("full_before_boundary", 32'(lights), 32'h0);
        checkOutput("settled_before_boundary", 32'(settled), 32'h0);
      end
      if (k == 17) begin
        checkOutput("full_after_boundary", 32'(lights), 32'h3f);
        checkOutput("settled_after_boundary", 32'(settled), 32'h1);
      end
    end
    repeat (20) @(negedge dimclk);
    checkOutput("full_constant", 32'(lights), 32'h3f);

    applyStimulus(1'b0, 1'b1, 6'b000000);
    repeat (40) @(negedge dimclk);
    dutyOfChannel(0, highs);
    checkOutput("dim_duty_ch0", 32'(highs), 32'd8);
    dutyOfChannel(5, highs);
    checkOutput("dim_duty_ch5", 32'(highs), 32'd8);
    checkOutput("dark_instance_lights", 32'(darkLights), 32'h0);
    checkOutput("dark_instance_settled", 32'(darkSettled), 32'h1);
    checkOutput("bright_instance_lights", 32'(brightLights), 32'h3);
    checkOutput("bright_instance_settled", 32'(brightSettled), 32'h1);

    applyStimulus(1'b0, 1'b0, 6'b000101);
    repeat (40) @(negedge dimclk);
    checkOutput("direct_pattern", 32'(lights), 32'h05);
    waitPhase(5);
    patterns = 6'b000001;
    repeat (11) @(negedge dimclk);
    checkOutput("toggle_held_until_boundary", 32'(lights), 32'h05);
    @(negedge dimclk);
    checkOutput("toggle_after_boundary", 32'(lights), 32'h01);
    waitPhase(3);
    patterns = 6'b000011;
    repeat (3) @(negedge dimclk);
    patterns = 6'b000001;
    repeat (20) @(negedge dimclk);
    checkOutput("short_pulse_ignored", 32'(lights), 32'h01);

    applyStimulus(1'b0, 1'b1, 6'b000011);
    repeat (40) @(negedge dimclk);
    waitPhase(9);
    reset = 1'b1;
    @(negedge dimclk);
    checkOutput("midreset_lights", 32'(lights), 32'h0);
    checkOutput("midreset_settled", 32'(settled), 32'h1);
    reset = 1'b0;
    @(negedge dimclk);
    checkOutput("post_reset_dark", 32'(lights), 32'h0);
    repeat (40) @(negedge dimclk);
`endif
    checkEn = 0;
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
